// File: rtl/lsq_pkg.sv
// rtl/lsq_pkg.sv - shared types and width helpers for the load/store queue
//
// Purpose: FSM state encoding and width helpers for the pointer, count and
// wait-counter registers used by load_store_queue and lsq_buffer.
// Ports: none (package).
package lsq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    WAIT  = 2'd3
  } ls_state_t;

  // Pointer width; DEPTH is a power of two >= 2 so pointers wrap naturally.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Count needs one extra bit to represent "full" (count == DEPTH).
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Wait counter holds at most cycles-1; keep at least one bit.
  function automatic int wait_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/lsq_buffer.sv
// rtl/lsq_buffer.sv - circular word buffer with count-based full/empty
//
// Purpose: DEPTH-entry circular buffer. Writes go to mem[wr_ptr], reads are
// combinational from mem[rd_ptr]. Full/empty come only from count.
// Ports:
//   clock, resetn  rising-edge clock, synchronous active-low reset
//   wr_en, wr_data write request and word (ignored when full)
//   rd_en          pop request (ignored when empty)
//   rd_data        oldest word, 0 while empty
//   count          entries currently held
module lsq_buffer
  import lsq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full;
  logic              empty;
  logic              do_wr;
  logic              do_rd;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      // A write and a pop in the same cycle cancel out in the count.
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; stale entries are unreachable once count is 0.
  always_ff @(posedge clock) begin
    if (resetn && do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/load_store_queue.sv
// rtl/load_store_queue.sv - load/store front end sequencing words into a buffer
//
// Purpose: accepts one word at a time, steps it through IDLE -> LOAD ->
// STORE -> WAIT and writes it into lsq_buffer, which drains independently.
// Ports:
//   clock, resetn        rising-edge clock, synchronous active-low reset
//   in_valid/in_ready    upstream handshake, in_data sampled on handshake
//   out_valid/out_ready  downstream handshake, out_data is the oldest word
//   count                entries currently buffered
//   state_o              current FSM state (IDLE=0 LOAD=1 STORE=2 WAIT=3)
module load_store_queue
  import lsq_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic [1:0]             state_o
);

  localparam int WAIT_W = wait_w(WAIT_CYCLES);
  localparam int CNT_W  = cnt_w(DEPTH);

  ls_state_t         state;
  ls_state_t         state_nxt;
  logic [DATA_W-1:0] stage;
  logic [WAIT_W-1:0] wait_cnt;
  logic              accept;

  // Only one word is ever in flight, so checking space in IDLE guarantees
  // STORE never meets a full buffer.
  assign in_ready = resetn && (state == IDLE) && (count < CNT_W'(DEPTH));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    state_nxt = STORE;
      STORE:   state_nxt = WAIT;
      WAIT:    if (wait_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state    <= IDLE;
      stage    <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) stage <= in_data;
      // WAIT_CYCLES-1 loaded here so WAIT exits on the cycle the counter is 0.
      if (state == STORE)
        wait_cnt <= WAIT_W'(WAIT_CYCLES - 1);
      else if (state == WAIT && wait_cnt != '0)
        wait_cnt <= wait_cnt - 1'b1;
    end
  end

  lsq_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_buffer (
    .clock   (clock),
    .resetn  (resetn),
    .wr_en   (state == STORE),
    .wr_data (stage),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .count   (count)
  );

  assign out_valid = (count != '0);
  assign state_o   = state;

endmodule

// File: tb/tb_load_store_queue.sv
// tb/tb_load_store_queue.sv - self-checking bench for load_store_queue
module tb_load_store_queue;

  localparam int DEPTH = 4;
  localparam int W     = 2;

  logic       clock = 1'b0;
  always #5 clock = ~clock;

  logic       resetn = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic [2:0] count;
  logic [1:0] state_o;

  logic       resetn1 = 1'b0;
  logic       in_valid1 = 1'b0;
  logic [7:0] in_data1 = '0;
  logic       in_ready1;
  logic       out_valid1;
  logic [7:0] out_data1;
  logic       out_ready1 = 1'b0;
  logic [2:0] count1;
  logic [1:0] state_o1;

  load_store_queue #(.DATA_W(8), .DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .count(count), .state_o(state_o)
  );

  load_store_queue #(.DATA_W(8), .DEPTH(DEPTH), .WAIT_CYCLES(1)) dut1 (
    .clock(clock), .resetn(resetn1), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
    .out_ready(out_ready1), .count(count1), .state_o(state_o1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: a queue of buffered words plus "cycles since the word
  // was accepted" for the single word in flight.
  bit [7:0] mq[$];
  bit [7:0] send_q[$];
  bit       busy = 0;
  int       phase = 0;
  bit [7:0] staged = 0;
  bit       just_reset = 1;
  int       cyc = 0;
  int       hs_cyc[$];

  function automatic int exp_state();
    if (!busy) return 0;
    if (phase == 0) return 1;
    if (phase == 1) return 2;
    return 3;
  endfunction

  task automatic tick();
    bit exp_ready, hs, pop, store;
    in_valid = (send_q.size() != 0);
    in_data  = in_valid ? send_q[0] : 8'($urandom);
    #1;
    exp_ready = resetn && !busy && (mq.size() < DEPTH);
    check("in_ready", in_ready, exp_ready);
    check("out_valid", out_valid, mq.size() != 0);
    check("count", count, mq.size());
    check("state_o", state_o, exp_state());
    if (mq.size() != 0) check("out_data", out_data, mq[0]);
    else if (just_reset) check("out_data_rst", out_data, 0);
    if (!resetn) begin
      mq.delete();
      busy = 0; phase = 0; staged = 0; just_reset = 1;
    end else begin
      just_reset = 0;
      hs    = in_valid && exp_ready;
      pop   = out_ready && (mq.size() != 0);
      store = busy && (phase == 1);
      if (pop) void'(mq.pop_front());
      if (store) mq.push_back(staged);
      if (busy) begin
        phase++;
        if (phase == 2 + W) busy = 0;
      end
      if (hs) begin
        busy = 1; phase = 0; staged = in_data;
        void'(send_q.pop_front());
        hs_cyc.push_back(cyc);
      end
    end
    cyc++;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic settle(input int max);
    int k = 0;
    while ((send_q.size() != 0 || busy) && k < max) begin tick(); k++; end
    if (send_q.size() != 0 || busy) check("settle_timeout", 1, 0);
  endtask

  task automatic drain_all(input int max);
    int k = 0;
    out_ready = 1;
    while (mq.size() != 0 && k < max) begin tick(); k++; end
    out_ready = 0;
    if (mq.size() != 0) check("drain_timeout", 1, 0);
  endtask

  task automatic until_store(input int max);
    int k = 0;
    while (!(busy && phase == 1) && k < max) begin tick(); k++; end
    if (!(busy && phase == 1)) check("store_timeout", 1, 0);
  endtask

  initial begin
    logic [1:0] pat1 [5];
    logic [1:0] patw1 [8];
    logic [7:0] fill [4];
    pat1  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
    patw1 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    fill  = '{8'h10, 8'h20, 8'h30, 8'h40};

    repeat (2) @(posedge clock);
    @(negedge clock);
    tick();                       // reset still asserted: in_ready must be 0
    resetn = 1;

    // Single word A5
    send_q.push_back(8'hA5);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("seq1_state", state_o, pat1[i]);
      check("seq1_valid", out_valid, (i >= 2));
      tick();
    end
    check("seq1_count", count, 1);
    check("seq1_data", out_data, 8'hA5);
    out_ready = 1; tick(); out_ready = 0;
    check("seq1_pop", count, 0);

    // Back-to-back 01..04, then a blocked 5th word
    hs_cyc.delete();
    for (int i = 1; i <= 4; i++) send_q.push_back(8'(i));
    settle(60);
    for (int i = 1; i < 4; i++) check("spacing", hs_cyc[i] - hs_cyc[i-1], 3 + W);
    check("full_count", count, 4);
    send_q.push_back(8'h05);
    repeat (10) tick();
    check("full_blocked", send_q.size(), 1);
    check("full_in_ready", in_ready, 0);
    out_ready = 1; tick(); out_ready = 0;
    settle(20);
    check("fifth_in", count, 4);
    drain_all(20);

    // Drain order
    for (int i = 0; i < 4; i++) send_q.push_back(fill[i]);
    settle(60);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check("drain_order", out_data, fill[i]);
      tick();
    end
    out_ready = 0;
    check("drain_empty", out_valid, 0);

    // Simultaneous store and pop with count = 2, then wrap traffic
    send_q.push_back(8'h51); send_q.push_back(8'h52);
    settle(30);
    send_q.push_back(8'h53);
    until_store(10);
    out_ready = 1; tick(); out_ready = 0;
    check("simul_count", count, 2);
    check("simul_head", out_data, 8'h52);
    for (int i = 0; i < 6; i++) send_q.push_back(8'($urandom));
    begin
      int k = 0;
      while ((send_q.size() != 0 || busy) && k < 200) begin
        out_ready = $urandom_range(0, 1);
        tick(); k++;
      end
      if (send_q.size() != 0 || busy) check("wrap_timeout", 1, 0);
    end
    drain_all(20);

    // Reset in STORE with count = 3
    for (int i = 0; i < 3; i++) send_q.push_back(8'h60 + 8'(i));
    settle(40);
    send_q.push_back(8'h99);
    until_store(10);
    resetn = 0; tick(); resetn = 1;
    check("rst_state", state_o, 0);
    check("rst_count", count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    repeat (8) tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      out_ready = $urandom_range(0, 1);
      resetn = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 3) == 0 && send_q.size() < 3) send_q.push_back(8'($urandom));
      tick();
    end
    resetn = 1;
    send_q.delete();
    settle(20);

    // WAIT_CYCLES = 1 instance: 4-cycle handshake spacing
    resetn1 = 1; in_valid1 = 1; in_data1 = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("w1_state", state_o1, patw1[i]);
      @(negedge clock);
    end
    #1;
    check("w1_count", count1, 2);
    check("w1_data", out_data1, 8'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
